// File: rtl/ip_crpr_arb_n.sv
// N-port credit-return arbiter: per-port, per-class event FIFOs drained one
// event per class per cycle by independent round-robin arbiters.
module ip_crpr_arb_n #(
    parameter int NPORTS = 4,
    parameter int NUMW   = 8,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NPORTS-1:0]        ph_cr_i,
    input  logic [NPORTS-1:0]        pd_cr_i,
    input  logic [NPORTS*NUMW-1:0]   pd_num_i,
    input  logic [NPORTS-1:0]        nph_cr_i,
    input  logic [NPORTS-1:0]        npd_cr_i,
    output logic                     ph_cr,
    output logic                     pd_cr,
    output logic [NUMW-1:0]          pd_num,
    output logic                     nph_cr,
    output logic                     npd_cr,
    output logic [NPORTS-1:0]        ovf,
    output logic                     busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(NPORTS);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [NUMW:0]   p_mem [NPORTS][DEPTH];
    logic [AW-1:0]   p_wr  [NPORTS];
    logic [AW-1:0]   p_rd  [NPORTS];
    logic [AW:0]     p_cnt [NPORTS];
    logic [PW-1:0]   p_rr;

    logic            n_mem [NPORTS][DEPTH];
    logic [AW-1:0]   n_wr  [NPORTS];
    logic [AW-1:0]   n_rd  [NPORTS];
    logic [AW:0]     n_cnt [NPORTS];
    logic [PW-1:0]   n_rr;

    logic [NPORTS-1:0] p_req, n_req, p_pop, n_pop, p_push, n_push;
    logic              p_gv, n_gv;
    logic [PW-1:0]     p_g, n_g;

    // Returns {valid, index} of the first requester at or after ptr, with wrap.
    function automatic logic [PW:0] rr_pick(input logic [NPORTS-1:0] req,
                                            input logic [PW-1:0] ptr);
        logic [PW:0] res;
        logic [PW:0] c;
        res = '0;
        for (int i = NPORTS - 1; i >= 0; i--) begin
            c = {1'b0, ptr} + (PW+1)'(i);
            if (c >= (PW+1)'(NPORTS))
                c = c - (PW+1)'(NPORTS);
            if (req[c[PW-1:0]])
                res = {1'b1, c[PW-1:0]};
        end
        return res;
    endfunction

    always_comb begin
        p_req = '0;
        n_req = '0;
        for (int p = 0; p < NPORTS; p++) begin
            p_req[p] = (p_cnt[p] != '0);
            n_req[p] = (n_cnt[p] != '0);
        end
        {p_gv, p_g} = rr_pick(p_req, p_rr);
        {n_gv, n_g} = rr_pick(n_req, n_rr);
        p_pop  = '0;
        n_pop  = '0;
        p_push = '0;
        n_push = '0;
        for (int p = 0; p < NPORTS; p++) begin
            p_pop[p]  = p_gv && (p_g == PW'(p));
            n_pop[p]  = n_gv && (n_g == PW'(p));
            // A full FIFO still accepts when its head leaves in the same cycle.
            p_push[p] = ph_cr_i[p]  && ((p_cnt[p] != FULL) || p_pop[p]);
            n_push[p] = nph_cr_i[p] && ((n_cnt[p] != FULL) || n_pop[p]);
        end
        busy = (|p_req) | (|n_req);
    end

    always_ff @(posedge clk) begin
        for (int p = 0; p < NPORTS; p++) begin
            if (p_push[p])
                p_mem[p][p_wr[p]] <= {pd_cr_i[p], pd_num_i[p*NUMW +: NUMW]};
            if (n_push[p])
                n_mem[p][n_wr[p]] <= npd_cr_i[p];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int p = 0; p < NPORTS; p++) begin
                p_wr[p]  <= '0;
                p_rd[p]  <= '0;
                p_cnt[p] <= '0;
                n_wr[p]  <= '0;
                n_rd[p]  <= '0;
                n_cnt[p] <= '0;
            end
        end else begin
            for (int p = 0; p < NPORTS; p++) begin
                if (p_push[p]) p_wr[p] <= p_wr[p] + AW'(1);
                if (p_pop[p])  p_rd[p] <= p_rd[p] + AW'(1);
                if (p_push[p] && !p_pop[p])
                    p_cnt[p] <= p_cnt[p] + (AW+1)'(1);
                else if (!p_push[p] && p_pop[p])
                    p_cnt[p] <= p_cnt[p] - (AW+1)'(1);

                if (n_push[p]) n_wr[p] <= n_wr[p] + AW'(1);
                if (n_pop[p])  n_rd[p] <= n_rd[p] + AW'(1);
                if (n_push[p] && !n_pop[p])
                    n_cnt[p] <= n_cnt[p] + (AW+1)'(1);
                else if (!n_push[p] && n_pop[p])
                    n_cnt[p] <= n_cnt[p] - (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            ovf <= '0;
        else
            ovf <= ovf | (ph_cr_i & ~p_push) | (nph_cr_i & ~n_push);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ph_cr  <= 1'b0;
            pd_cr  <= 1'b0;
            pd_num <= '0;
            nph_cr <= 1'b0;
            npd_cr <= 1'b0;
            p_rr   <= '0;
            n_rr   <= '0;
        end else begin
            ph_cr <= p_gv;
            if (p_gv) begin
                {pd_cr, pd_num} <= p_mem[p_g][p_rd[p_g]];
                p_rr <= (p_g == PW'(NPORTS - 1)) ? '0 : p_g + PW'(1);
            end else begin
                pd_cr  <= 1'b0;
                pd_num <= '0;
            end
            nph_cr <= n_gv;
            if (n_gv) begin
                npd_cr <= n_mem[n_g][n_rd[n_g]];
                n_rr   <= (n_g == PW'(NPORTS - 1)) ? '0 : n_g + PW'(1);
            end else begin
                npd_cr <= 1'b0;
            end
        end
    end

endmodule
